// File: rtl/ddr_read_responder.sv
// ddr_read_responder: on a rising edge of the read request, issues one read
// burst to the memory controller, pops the returned 32-bit words and streams
// them little-endian, one byte per cycle, into the USB byte FIFO. Ends with
// a one-cycle done pulse, either on completion or on a read-data timeout.
module ddr_read_responder #(
  parameter int BURST_WORDS = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        rd_req_i,
  input  logic [31:0] rd_address_i,
  output logic        rd_done_o,
  output logic        rd_error_o,
  output logic        busy_o,
  output logic        cmd_en_o,
  output logic [2:0]  cmd_instr_o,
  output logic [29:0] cmd_byte_addr_o,
  output logic [5:0]  cmd_bl_o,
  input  logic        cmd_full_i,
  output logic        mem_rd_en_o,
  input  logic [31:0] mem_rd_data_i,
  input  logic        mem_rd_empty_i,
  output logic [7:0]  fifo_din_o,
  output logic        fifo_wr_en_o,
  input  logic        fifo_full_i
);

  localparam int WCW = $clog2(BURST_WORDS + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_FETCH, S_CAP, S_SHIFT, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic           req_q;
  logic [29:0]    addr_q, addr_d;
  logic           err_q, err_d;
  logic [WCW-1:0] words_q, words_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic [31:0]    shift_q, shift_d;
  logic [1:0]     bidx_q, bidx_d;
  logic           rise;
  logic           pop;

  // Address bits below word granularity and above the 1 GB window are unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_address_i[31:30], rd_address_i[1:0]};

  assign rise = rd_req_i & ~req_q;

  // State and datapath registers; reset drops everything back to idle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      words_q <= '0;
      tmo_q   <= '0;
      shift_q <= '0;
      bidx_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= rd_req_i;
      addr_q  <= addr_d;
      err_q   <= err_d;
      words_q <= words_d;
      tmo_q   <= tmo_d;
      shift_q <= shift_d;
      bidx_q  <= bidx_d;
    end
  end

  // Next-state logic and strobes. On the last byte of a word the next word
  // is popped in the same cycle when available, giving 4 bytes per 5 cycles.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    err_d        = err_q;
    words_d      = words_q;
    tmo_d        = tmo_q;
    shift_d      = shift_q;
    bidx_d       = bidx_q;
    cmd_en_o     = 1'b0;
    pop          = 1'b0;
    fifo_wr_en_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_CMD;
          addr_d  = {rd_address_i[29:2], 2'b00};
          err_d   = 1'b0;
          words_d = '0;
          tmo_d   = '0;
          bidx_d  = '0;
        end
      end
      S_CMD: begin
        if (!cmd_full_i) begin
          cmd_en_o = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!mem_rd_empty_i) begin
          pop     = 1'b1;
          state_d = S_CAP;
        end else if (tmo_q == TCW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TCW'(1);
        end
      end
      S_CAP: begin
        shift_d = mem_rd_data_i;
        bidx_d  = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (!fifo_full_i) begin
          fifo_wr_en_o = 1'b1;
          shift_d      = {8'h00, shift_q[31:8]};
          bidx_d       = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            if (words_q == WCW'(BURST_WORDS)) begin
              state_d = S_DONE;
            end else if (!mem_rd_empty_i) begin
              pop     = 1'b1;
              state_d = S_CAP;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      words_d = words_q + WCW'(1);
      tmo_d   = '0;
    end
  end

  assign mem_rd_en_o     = pop;
  assign rd_done_o       = (state_q == S_DONE);
  assign busy_o          = (state_q != S_IDLE);
  assign rd_error_o      = err_q;
  assign cmd_instr_o     = cmd_en_o ? 3'b001 : 3'b000;
  assign cmd_byte_addr_o = addr_q;
  assign cmd_bl_o        = 6'(BURST_WORDS - 1);
  assign fifo_din_o      = shift_q[7:0];

endmodule

// File: tb/tb_ddr_read_responder.sv
// Bench for ddr_read_responder: a queue-based memory controller model and a
// byte-stream reference built from the returned words.
module tb_ddr_read_responder;
  localparam int BW = 16;
  localparam int TO = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n_i, rd_req_i, rd_done_o, rd_error_o, busy_o, cmd_en_o;
  logic [31:0] rd_address_i, mem_rd_data_i;
  logic [2:0]  cmd_instr_o;
  logic [29:0] cmd_byte_addr_o;
  logic [5:0]  cmd_bl_o;
  logic        cmd_full_i, mem_rd_en_o, mem_rd_empty_i, fifo_wr_en_o, fifo_full_i;
  logic [7:0]  fifo_din_o;

  ddr_read_responder #(.BURST_WORDS(BW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .rd_req_i(rd_req_i),
    .rd_address_i(rd_address_i), .rd_done_o(rd_done_o), .rd_error_o(rd_error_o),
    .busy_o(busy_o), .cmd_en_o(cmd_en_o), .cmd_instr_o(cmd_instr_o),
    .cmd_byte_addr_o(cmd_byte_addr_o), .cmd_bl_o(cmd_bl_o), .cmd_full_i(cmd_full_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_rd_data_i(mem_rd_data_i),
    .mem_rd_empty_i(mem_rd_empty_i), .fifo_din_o(fifo_din_o),
    .fifo_wr_en_o(fifo_wr_en_o), .fifo_full_i(fifo_full_i)
  );

  typedef struct {
    logic [31:0] addr;
    bit          pattern;
    int          avail, full_pct, empty_pct, cmd_hold, mid_edge, hold;
    logic [31:0] exp_addr;
    bit          exp_err;
  } vec_t;

  int n_chk = 0, n_pass = 0;
  // stimulus knobs
  bit req_lvl = 1'b0;
  int full_pct = 0, empty_pct = 0, cmd_hold = 0, avail = 0;
  // controller model and monitors
  logic [31:0] words[$];
  logic [31:0] rdq[$];
  logic [7:0]  got[$];
  logic [29:0] cmd_addr;
  int cyc = 0, cmd_cnt, done_cnt, bad, first_pop, last_pop, first_wr, last_wr;
  int done_cyc, cmd_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock: drive inputs at negedge, observe settled outputs 1ns later.
  task automatic step();
    @(negedge clk);
    rd_req_i       = req_lvl;
    cmd_full_i     = (cmd_hold > 0);
    fifo_full_i    = ($urandom_range(99) < full_pct);
    mem_rd_empty_i = (rdq.size() == 0) || ($urandom_range(99) < empty_pct);
    #1;
    cyc++;
    if (cmd_hold > 0) cmd_hold--;
    if (fifo_wr_en_o) begin
      if (fifo_full_i) bad++;
      got.push_back(fifo_din_o);
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    if (cmd_en_o) begin
      if (cmd_full_i || cmd_instr_o != 3'b001) bad++;
      cmd_cnt++;
      cmd_addr = cmd_byte_addr_o;
      cmd_cyc  = cyc;
      for (int i = 0; i < avail && i < words.size(); i++) rdq.push_back(words[i]);
    end
    if (mem_rd_en_o) begin
      if (mem_rd_empty_i) bad++;
      else begin
        mem_rd_data_i = rdq.pop_front();
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
    if (rd_done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic clear_mon();
    got.delete();
    cmd_cnt = 0; done_cnt = 0; bad = 0; first_pop = -1; first_wr = -1;
    last_pop = 0; last_wr = 0; done_cyc = 0; cmd_cyc = 0;
  endtask

  task automatic run_request(input vec_t v);
    int c0, n, nw;
    bit tog;
    words.delete();
    for (int i = 0; i < BW; i++)
      words.push_back(v.pattern ? 32'(32'h03020100 + 32'h04040404 * i) : $urandom());
    avail = v.avail; full_pct = v.full_pct; empty_pct = v.empty_pct;
    clear_mon();
    rd_address_i = v.addr;
    req_lvl = 1'b1;
    step();
    c0 = cyc;
    cmd_hold = v.cmd_hold;
    step();
    check("busy_after_accept", 32'(busy_o), 1);
    check("err_cleared_on_accept", 32'(rd_error_o), 0);
    n = 0; tog = 1'b0;
    while (done_cnt == 0 && n < TO + 600) begin
      if (v.mid_edge != 0 && !tog && got.size() >= 10) begin
        req_lvl = 1'b0; step(); req_lvl = 1'b1; tog = 1'b1;
      end
      step();
      n++;
    end
    check("done_within_bound", 32'(done_cnt > 0), 1);
    repeat (v.hold) step();
    req_lvl = 1'b0;
    step(); step();
    nw = v.exp_err ? v.avail : BW;
    check("cmd_count", 32'(cmd_cnt), 1);
    check("cmd_addr", 32'(cmd_addr), v.exp_addr);
    check("cmd_wait", 32'(cmd_cyc - c0), 32'(v.cmd_hold + 1));
    check("done_count", 32'(done_cnt), 1);
    check("rd_error", 32'(rd_error_o), 32'(v.exp_err));
    check("busy_after_done", 32'(busy_o), 0);
    check("protocol_violations", 32'(bad), 0);
    check("byte_count", 32'(got.size()), 32'(4 * nw));
    for (int i = 0; i < got.size() && i < 4 * nw; i++)
      check($sformatf("byte[%0d]", i), 32'(got[i]), 32'(8'(words[i / 4] >> (8 * (i % 4)))));
    if (v.exp_err) begin
      check("timeout_gap", 32'((done_cyc - last_pop) >= TO && (done_cyc - last_pop) <= TO + 8), 1);
    end else if (v.full_pct == 0 && v.empty_pct == 0) begin
      check("first_byte_latency", 32'(first_wr - first_pop), 2);
      check("stream_throughput", 32'(last_wr - first_wr), 32'(5 * BW - 2));
    end
  endtask

  vec_t tbl[6];
  vec_t rv;
  int   rst_bytes;

  initial begin
    // addr, pattern, avail, full%, empty%, cmd_hold, mid_edge, hold, exp_addr, exp_err
    tbl[0] = '{32'h0000_1003, 1'b1, 16,  0, 0,  0, 0,  0, 32'h0000_1000, 1'b0};
    tbl[1] = '{32'h0000_1003, 1'b1, 16, 40, 0,  0, 0,  0, 32'h0000_1000, 1'b0};
    tbl[2] = '{32'hC000_2006, 1'b1, 16,  0, 0, 20, 0,  0, 32'h0000_2004, 1'b0};
    tbl[3] = '{32'h0000_0100, 1'b1,  5,  0, 0,  0, 0,  0, 32'h0000_0100, 1'b1};
    tbl[4] = '{32'h0000_0200, 1'b1, 16,  0, 0,  0, 1, 10, 32'h0000_0200, 1'b0};
    tbl[5] = '{32'h3FFF_FFFF, 1'b0, 16, 20, 20, 3, 0,  0, 32'h3FFF_FFFC, 1'b0};

    reset_n_i = 1'b0; rd_req_i = 1'b0; rd_address_i = '0; cmd_full_i = 1'b0;
    mem_rd_data_i = '0; mem_rd_empty_i = 1'b1; fifo_full_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl_outputs",
          32'({rd_done_o, rd_error_o, busy_o, cmd_en_o, cmd_instr_o, mem_rd_en_o, fifo_wr_en_o}), 0);
    check("reset_addr", 32'(cmd_byte_addr_o), 0);
    check("reset_din", 32'(fifo_din_o), 0);
    check("cmd_bl", 32'(cmd_bl_o), 32'(BW - 1));
    reset_n_i = 1'b1;

    for (int t = 0; t < 6; t++) run_request(tbl[t]);

    // randomized requests against the reference byte stream
    for (int r = 0; r < 6; r++) begin
      rv.addr      = $urandom();
      rv.pattern   = 1'b0;
      rv.avail     = BW;
      rv.full_pct  = int'($urandom_range(50));
      rv.empty_pct = int'($urandom_range(30));
      rv.cmd_hold  = int'($urandom_range(4));
      rv.mid_edge  = int'($urandom_range(1));
      rv.hold      = int'($urandom_range(3));
      rv.exp_addr  = rv.addr & 32'h3FFF_FFFC;
      rv.exp_err   = 1'b0;
      run_request(rv);
    end

    // reset in the middle of SHIFT: outputs drop at once, no done pulse
    words.delete();
    for (int i = 0; i < BW; i++) words.push_back(32'(32'h03020100 + 32'h04040404 * i));
    avail = BW; full_pct = 0; empty_pct = 0;
    clear_mon();
    rd_address_i = 32'h0000_4000;
    req_lvl = 1'b1;
    for (int n = 0; n < 200 && got.size() < 6; n++) step();
    check("reached_shift", 32'(got.size() >= 6), 1);
    #2 reset_n_i = 1'b0;
    #1;
    check("midreset_ctrl_outputs",
          32'({rd_done_o, rd_error_o, busy_o, cmd_en_o, cmd_instr_o, mem_rd_en_o, fifo_wr_en_o}), 0);
    check("midreset_addr", 32'(cmd_byte_addr_o), 0);
    check("midreset_din", 32'(fifo_din_o), 0);
    rdq.delete();
    req_lvl = 1'b0;
    rst_bytes = got.size();
    done_cnt = 0;
    repeat (3) step();
    reset_n_i = 1'b1;
    repeat (10) step();
    check("no_done_after_reset", 32'(done_cnt), 0);
    check("idle_after_reset", 32'(busy_o), 0);
    check("no_bytes_after_reset", 32'(got.size()), 32'(rst_bytes));

    // normal operation resumes
    run_request(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
